// File: rtl/cms_pix28_package.sv
`default_nettype none
// ==== cms_pix28_package : shared firmware IDs and pin-arbiter types ==== rev 1.1 ====
package cms_pix28_package;

  localparam logic [3:0] firmware_id_1 = 4'h1;
  localparam logic [3:0] firmware_id_2 = 4'h2;
  localparam logic [3:0] firmware_id_3 = 4'h3;
  localparam logic [3:0] firmware_id_4 = 4'h4;
  localparam logic [3:0] FW_ID_NONE    = 4'h0;

  typedef logic [1:0] fw_arb_state_t;
  localparam fw_arb_state_t ARB_IDLE      = 2'd0;
  localparam fw_arb_state_t ARB_GUARD     = 2'd1;
  localparam fw_arb_state_t ARB_CONNECTED = 2'd2;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } fw_idx_t;

  function automatic logic fw_id_valid(input logic [3:0] id, input int num_fw);
    return (id != FW_ID_NONE) && (int'(id) <= num_fw);
  endfunction

  // firmware_id_k maps to fw index k-1; anything outside 1..num_fw is "none".
  function automatic fw_idx_t fw_id_to_index(input logic [3:0] id, input int num_fw);
    fw_idx_t r;
    r.valid = fw_id_valid(id, num_fw);
    r.idx   = r.valid ? (id - 4'd1) : 4'd0;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/com_in_sync.sv
`default_nettype none
// ==== com_in_sync : STAGES-deep input flop chain, first stage is the IOB FF ==== rev 1.0 ====
module com_in_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      r_q[0] <= i_d;
      for (int s = 1; s < STAGES; s++) begin
        r_q[s] <= r_q[s-1];
      end
    end
  end

  assign o_q = r_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/com_fw_to_dut_arb.sv
`default_nettype none
// ==== com_fw_to_dut_arb : firmware-to-DUT pin arbiter with guarded switchover ==== rev 2.0 ====
module com_fw_to_dut_arb
  import cms_pix28_package::*;
#(
  parameter int                       NUM_FW         = 4,
  parameter int                       NUM_OUT        = 10,
  parameter int                       NUM_IN         = 7,
  parameter int                       GUARD_CYCLES   = 16,
  parameter int                       IN_SYNC_STAGES = 2,
  parameter logic [NUM_OUT-1:0]       OUT_DEFAULT    = 10'b0000010100,
  parameter logic [NUM_OUT-1:0]       OUT_FIXED_MASK = 10'b0001100010,
  parameter logic [NUM_OUT*4-1:0]     OUT_FIXED_SEL  = 40'h0001100000
) (
  input  logic                        iob_clk,
  input  logic                        iob_reset,
  input  logic [3:0]                  fw_dev_id_enable,
  input  logic [NUM_FW*NUM_OUT-1:0]   fw_out,
  output logic [NUM_FW*NUM_IN-1:0]    fw_in,
  output logic [NUM_OUT-1:0]          dut_out,
  input  logic [NUM_IN-1:0]           dut_in,
  output logic [3:0]                  active_fw,
  output logic                        switch_busy,
  output logic [15:0]                 switch_count
);

  localparam int               CW           = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [CW-1:0]    c_GUARD_LOAD = CW'(GUARD_CYCLES - 1);

  fw_arb_state_t        r_state;
  logic [CW-1:0]        r_cnt;
  logic [3:0]           r_target;
  logic [3:0]           r_owner;
  logic [NUM_OUT-1:0]   r_dut_out;
  logic [3:0]           r_active_fw;
  logic                 r_switch_busy;
  logic [15:0]          r_switch_count;

  fw_arb_state_t        w_state_nxt;
  logic [CW-1:0]        w_cnt_nxt;
  logic [3:0]           w_target_nxt;
  logic [3:0]           w_owner_nxt;
  logic                 w_connect;
  fw_idx_t              w_own;
  logic [NUM_IN-1:0]    w_sync;
  logic [NUM_OUT-1:0]   w_mux;
  logic [NUM_OUT-1:0]   w_fixed;
  logic [NUM_OUT-1:0]   w_pin_nxt;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_in_sync
    com_in_sync #(
      .STAGES (IN_SYNC_STAGES)
    ) u_sync (
      .clk (iob_clk),
      .rst (iob_reset),
      .i_d (dut_in[i]),
      .o_q (w_sync[i])
    );
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_target_nxt = r_target;
    w_owner_nxt  = r_owner;
    w_connect    = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (fw_id_valid(fw_dev_id_enable, NUM_FW)) begin
          w_target_nxt = fw_dev_id_enable;
          w_cnt_nxt    = c_GUARD_LOAD;
          w_state_nxt  = ARB_GUARD;
        end
      end
      ARB_GUARD: begin
        // A request that moves during the guard restarts the full park period.
        if (fw_dev_id_enable != r_target) begin
          w_target_nxt = fw_dev_id_enable;
          w_cnt_nxt    = c_GUARD_LOAD;
        end else if (r_cnt == '0) begin
          if (fw_id_valid(r_target, NUM_FW)) begin
            w_owner_nxt = r_target;
            w_state_nxt = ARB_CONNECTED;
            w_connect   = 1'b1;
          end else begin
            w_state_nxt = ARB_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      ARB_CONNECTED: begin
        if (fw_dev_id_enable != r_owner) begin
          w_target_nxt = fw_dev_id_enable;
          w_cnt_nxt    = c_GUARD_LOAD;
          w_owner_nxt  = FW_ID_NONE;
          w_state_nxt  = ARB_GUARD;
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  assign w_own = fw_id_to_index(r_owner, NUM_FW);

  always_comb begin
    w_mux = OUT_DEFAULT;
    fw_in = '0;
    if ((r_state == ARB_CONNECTED) && w_own.valid) begin
      for (int f = 0; f < NUM_FW; f++) begin
        if (w_own.idx == 4'(f)) begin
          w_mux                    = fw_out[f*NUM_OUT +: NUM_OUT];
          fw_in[f*NUM_IN +: NUM_IN] = w_sync;
        end
      end
    end
  end

  // Fixed-owner pins tap their firmware directly and never see the park value.
  for (genvar p = 0; p < NUM_OUT; p++) begin : g_pin
    if (OUT_FIXED_MASK[p]) begin : g_fixed
      localparam int SEL = int'(OUT_FIXED_SEL[p*4 +: 4]);
      assign w_fixed[p] = fw_out[SEL*NUM_OUT + p];
    end else begin : g_muxed
      assign w_fixed[p] = 1'b0;
    end
  end

  assign w_pin_nxt = (w_mux & ~OUT_FIXED_MASK) | (w_fixed & OUT_FIXED_MASK);

  always_ff @(posedge iob_clk) begin
    if (iob_reset) begin
      r_state        <= ARB_IDLE;
      r_cnt          <= '0;
      r_target       <= FW_ID_NONE;
      r_owner        <= FW_ID_NONE;
      r_dut_out      <= OUT_DEFAULT & ~OUT_FIXED_MASK;
      r_active_fw    <= FW_ID_NONE;
      r_switch_busy  <= 1'b0;
      r_switch_count <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_target       <= w_target_nxt;
      r_owner        <= w_owner_nxt;
      r_dut_out      <= w_pin_nxt;
      r_active_fw    <= (w_state_nxt == ARB_CONNECTED) ? w_owner_nxt : FW_ID_NONE;
      r_switch_busy  <= (w_state_nxt == ARB_GUARD);
      if (w_connect && (r_switch_count != 16'hFFFF)) begin
        r_switch_count <= r_switch_count + 16'd1;
      end
    end
  end

  assign dut_out      = r_dut_out;
  assign active_fw    = r_active_fw;
  assign switch_busy  = r_switch_busy;
  assign switch_count = r_switch_count;

endmodule
`default_nettype wire

// File: tb/tb_com_fw_to_dut_arb.sv
`default_nettype none
// ==== tb_com_fw_to_dut_arb : directed self-checking bench for com_fw_to_dut_arb ==== rev 1.0 ====
module tb_com_fw_to_dut_arb;
  import cms_pix28_package::*;

  localparam logic [9:0] DEF = 10'b0000010100;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic [3:0]  id     = 4'h0;
  logic [39:0] fw_out = '0;
  logic [6:0]  dut_in = '0;
  logic [27:0] fw_in;
  logic [9:0]  dut_out;
  logic [3:0]  active_fw;
  logic        busy;
  logic [15:0] cnt;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [39:0] fw;
    logic [6:0]  din;
    logic [9:0]  exp_out;
    logic [27:0] exp_in;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  com_fw_to_dut_arb dut (
    .iob_clk          (clk),
    .iob_reset        (rst),
    .fw_dev_id_enable (id),
    .fw_out           (fw_out),
    .fw_in            (fw_in),
    .dut_out          (dut_out),
    .dut_in           (dut_in),
    .active_fw        (active_fw),
    .switch_busy      (busy),
    .switch_count     (cnt)
  );

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Expected pins: owner slice (or park value when owner < 0) with fixed pins 1<-fw0, 5/6<-fw1.
  function automatic logic [9:0] exp_pins(input logic [39:0] f, input int owner);
    logic [9:0] r;
    r    = (owner < 0) ? DEF : f[owner*10 +: 10];
    r[1] = f[1];
    r[5] = f[15];
    r[6] = f[16];
    return r;
  endfunction

  task automatic guard_ticks(input int n, input string tag);
    logic [39:0] p;
    for (int k = 0; k < n; k++) begin
      p      = {4{10'(k * 73 + 9)}};
      p[1]   = k[0];
      p[15]  = ~k[0];
      p[16]  = k[1];
      fw_out = p;
      tick();
      chk({tag, "_park"}, dut_out, exp_pins(p, -1));
      chk({tag, "_busy"}, busy, 1'b1);
    end
  endtask

  initial begin
    vecs[0] = '{{10'h2AA, 10'h155, 10'h3FF, 10'h000}, 7'h55, 10'h3FD, 28'h0002A80};
    vecs[1] = '{{10'h3FF, 10'h3FF, 10'h000, 10'h3FF}, 7'h2A, 10'h002, 28'h0001500};
    vecs[2] = '{{10'h000, 10'h000, 10'h155, 10'h2AA}, 7'h7F, 10'h157, 28'h0003F80};
    vecs[3] = '{{10'h3FF, 10'h000, 10'h2AA, 10'h155}, 7'h01, 10'h2A8, 28'h0000080};
    vecs[4] = '{{10'h000, 10'h000, 10'h060, 10'h001}, 7'h00, 10'h060, 28'h0000000};

    // Reset state
    tick();
    tick();
    chk("rst_dut_out", dut_out, DEF);
    chk("rst_active", active_fw, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", cnt, 16'h0);
    chk("rst_fw_in", fw_in, 28'h0);

    // First connect to fw index 1 is guarded
    rst = 1'b0;
    id  = firmware_id_2;
    guard_ticks(16, "s1_guard");
    tick();
    chk("s1_conn_busy", busy, 1'b0);
    chk("s1_conn_active", active_fw, firmware_id_2);
    chk("s1_conn_count", cnt, 16'd1);
    chk("s1_conn_pins_lag", dut_out, exp_pins(fw_out, -1));
    fw_out = {10'h0F0, 10'h00F, 10'h3C3, 10'h202};
    tick();
    chk("s1_conn_pins", dut_out, exp_pins(fw_out, 1));

    // Connected sweep: output mux and owner-only input delivery
    for (int v = 0; v < 5; v++) begin
      fw_out = vecs[v].fw;
      dut_in = vecs[v].din;
      tick();
      chk($sformatf("vec%0d_dut_out", v), dut_out, vecs[v].exp_out);
      tick();
      chk($sformatf("vec%0d_fw_in", v), fw_in, vecs[v].exp_in);
    end

    // 2 -> 3, back to 2 mid-guard: guard restarts
    id = firmware_id_3;
    tick();
    chk("s3_start_busy", busy, 1'b1);
    chk("s3_start_active", active_fw, 4'h0);
    chk("s3_start_fw_in", fw_in, 28'h0);
    chk("s3_start_pins", dut_out, exp_pins(fw_out, 1));
    guard_ticks(8, "s3_guard_a");
    id = firmware_id_2;
    guard_ticks(16, "s3_guard_b");
    tick();
    chk("s3_conn_busy", busy, 1'b0);
    chk("s3_conn_active", active_fw, firmware_id_2);
    chk("s3_conn_count", cnt, 16'd2);
    fw_out = {10'h111, 10'h222, 10'h0AB, 10'h3FD};
    dut_in = 7'h33;
    tick();
    chk("s3_conn_pins", dut_out, exp_pins(fw_out, 1));
    tick();
    chk("s3_conn_fw_in", fw_in, 28'h0001980);

    // Invalid ID: guard then idle
    id = 4'hF;
    tick();
    chk("s4_start_busy", busy, 1'b1);
    chk("s4_start_fw_in", fw_in, 28'h0);
    guard_ticks(15, "s4_guard");
    tick();
    chk("s4_idle_busy", busy, 1'b0);
    chk("s4_idle_active", active_fw, 4'h0);
    chk("s4_idle_count", cnt, 16'd2);
    fw_out = {10'h3FF, 10'h3FF, 10'h3FF, 10'h3FD};
    tick();
    chk("s4_idle_pins", dut_out, exp_pins(fw_out, -1));
    chk("s4_idle_fw_in", fw_in, 28'h0);

    // Reset during guard
    id = firmware_id_1;
    tick();
    chk("s6_start_busy", busy, 1'b1);
    guard_ticks(5, "s6_guard");
    fw_out = {40{1'b1}};
    rst    = 1'b1;
    tick();
    chk("s6_rst_pins", dut_out, DEF);
    chk("s6_rst_busy", busy, 1'b0);
    chk("s6_rst_count", cnt, 16'h0);
    rst = 1'b0;
    id  = FW_ID_NONE;
    tick();
    chk("s6_idle_busy", busy, 1'b0);
    chk("s6_idle_pins", dut_out, exp_pins(fw_out, -1));

    // Saturation of the switch counter
    force dut.r_switch_count = 16'hFFFF;
    tick();
    release dut.r_switch_count;
    tick();
    chk("s6_preload", cnt, 16'hFFFF);
    id = firmware_id_1;
    guard_ticks(16, "s6_guard2");
    tick();
    chk("s6_sat_count", cnt, 16'hFFFF);
    chk("s6_sat_active", active_fw, firmware_id_1);
    fw_out = {10'h000, 10'h060, 10'h3A5, 10'h15A};
    tick();
    chk("s6_fw0_pins", dut_out, exp_pins(fw_out, 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/com_fw_to_dut_arb.md
Name: com_fw_to_dut_arb

Overview:
Parametrised successor to the firmware-to-DUT pin multiplexer. It routes NUM_FW firmware blocks to one shared set of DUT pins through registered IOB stages. It adds a guarded switchover FSM: when the owning firmware changes, the pins are parked at safe defaults for a fixed number of cycles before the new owner is connected. It also adds multi-stage input synchronisers and per-pin fixed-owner overrides (e.g. config_clk always from fw index 0, bxclk/bxclk_ana always from fw index 1).

Parameters:
NUM_FW, 4, number of firmware blocks (1..15).
NUM_OUT, 10, number of FPGA-to-DUT output pins.
NUM_IN, 7, number of DUT-to-FPGA input pins.
GUARD_CYCLES, 16, cycles of parked defaults on every ownership change (>=1).
IN_SYNC_STAGES, 2, flop stages on each DUT input (>=1; stage 1 is the IOB FF).
OUT_DEFAULT, 10'b0000010100, park value per output pin (reset_not=1, config_load=1).
OUT_FIXED_MASK, 10'b0001100010, pins with a fixed owner that bypass the FSM.
OUT_FIXED_SEL, packed NUM_OUT*4 bits, fw index per fixed pin; ignored where the mask bit is 0.

Ports:
iob_clk  in  1  pin clock, 400 MHz.
iob_reset  in  1  synchronous, active-high reset.
fw_dev_id_enable  in  4  requested owner ID; firmware_id_k selects fw index k-1; any other value means "none".
fw_out  in  NUM_FW*NUM_OUT  firmware output bits, slice [f*NUM_OUT +: NUM_OUT] belongs to fw f.
fw_in  out  NUM_FW*NUM_IN  synchronised DUT inputs, delivered to the owner only.
dut_out  out  NUM_OUT  FPGA pins, driven from the IOB FF.
dut_in  in  NUM_IN  FPGA pins, captured by the IOB FF.
active_fw  out  4  ID of the currently connected owner; 0 when none.
switch_busy  out  1  high while in GUARD.
switch_count  out  16  number of completed switchovers, saturating.

Behaviour:
- Clock and reset: one clock (iob_clk). Reset (iob_reset) is synchronous and active-high.
- Values after reset:
  - FSM enters IDLE; guard counter = 0.
  - dut_out = OUT_DEFAULT, except fixed pins, which are registered from their owner from the first cycle.
  - All synchroniser flops = 0; fw_in = 0.
  - active_fw = 0, switch_busy = 0, switch_count = 0.
- FSM states: IDLE, GUARD, CONNECTED. The registers target (4b) and owner (4b) hold fw_dev_id_enable values.
- IDLE:
  - Non-fixed pins muxed to OUT_DEFAULT; fw_in = 0.
  - A valid ID arrives -> target = ID, counter = GUARD_CYCLES-1, go to GUARD. The first connect is also guarded.
- GUARD:
  - Same drive as IDLE.
  - If fw_dev_id_enable differs from target -> target = new value, counter reloaded (restart).
  - Otherwise, when counter = 0: if target is valid -> owner = target, go to CONNECTED, switch_count increments; if not -> go to IDLE.
  - Otherwise counter decrements.
- CONNECTED:
  - Non-fixed pins muxed from the owner's fw_out slice.
  - fw_in owner slice = synchroniser output; all other slices = 0.
  - If fw_dev_id_enable differs from owner (valid or not) -> target = new value, reload counter, go to GUARD; owner cleared.
- Timing:
  - Guard duration is exactly GUARD_CYCLES cycles of default drive at the mux, measured from the cycle after the ID change.
  - A steady request therefore connects GUARD_CYCLES+1 cycles after the ID change is sampled.
- Output latency: fw_out -> dut_out = 1 cycle (mux is combinational off the FSM state, then the IOB FF).
- Input latency: dut_in -> fw_in = IN_SYNC_STAGES cycles; gating is combinational off the FSM state.
- Fixed pins (OUT_FIXED_MASK=1): always fw_out[OUT_FIXED_SEL*NUM_OUT + pin] through the IOB FF. Unaffected by state or guard; only iob_reset forces them to 0 for the reset cycle.
- Reset mid-operation, at any state: returns to IDLE next cycle; any guard in progress is abandoned.
- Status outputs: active_fw = owner in CONNECTED, else 0; switch_busy = (state == GUARD), both registered. switch_count holds at 16'hFFFF.
- Invalid IDs (0, >NUM_FW, or non-package values) are never connected.

Decomposition:
- cms_pix28_package: add the typedef fw_arb_state_t (IDLE, GUARD, CONNECTED), the constant FW_ID_NONE = 4'h0, and a function fw_id_to_index() mapping firmware_id_k -> k-1 with a valid flag. The existing firmware_id_1..4 constants are reused.
- Sub-module com_in_sync: a parametrised IN_SYNC_STAGES-deep flop chain with synchronous reset, instantiated once per input bit.

Test Plan:
1. Reset, then hold ID=firmware_id_2 from cycle 0 -> dut_out = OUT_DEFAULT for 16 cycles, then fw index 1 bits appear on non-fixed pins; active_fw = firmware_id_2; switch_count = 1.
2. In CONNECTED, drive dut_in = 7'h55 -> fw_in fw1 slice = 7'h55 after 2 cycles; fw0, fw2 and fw3 slices stay 0.
3. Change ID 2 -> 3, then back to 2 at guard cycle 8 -> guard restarts; defaults held for 8+16 cycles total; reconnects to fw1; switch_count = 2.
4. Change ID to 4'hF -> 16 guard cycles, then IDLE; dut_out = OUT_DEFAULT; active_fw = 0; switch_count unchanged.
5. Toggle fw0 and fw1 bits on fixed pins (1, 5, 6) throughout scenarios 1–4 -> those dut_out bits follow with 1-cycle latency, including during GUARD and IDLE.
6. Assert iob_reset at guard cycle 5 -> next cycle IDLE, switch_busy = 0, dut_out = OUT_DEFAULT; switch_count preloaded to 16'hFFFF saturates on the next switch.
